deserialization_rx: RTL



---
 rtl/serial_link_pkg.sv | 21 ++
 rtl/deserialization_rx.sv | 84 ++++++++
 2 files changed

// File: rtl/serial_link_pkg.sv
// Shared frame layout for the accumulator serial link; serializer and receiver both import it.
// Frame is 2*ACC_DATA_WIDTH bits sent LSB first: SA word in the low half, CML word in the high half.
package serial_link_pkg;

    localparam int ACC_DATA_WIDTH_DEF = 32;
    localparam int FRAME_BITS         = 2 * ACC_DATA_WIDTH_DEF;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    localparam int SA_LSB = 0;

    function automatic int frame_bits(input int acc_width);
        return 2 * acc_width;
    endfunction

    function automatic int cml_lsb(input int acc_width);
        return acc_width;
    endfunction

endpackage

// File: rtl/deserialization_rx.sv
// Rebuilds LSB-first serial frames into SA/CML words; dataValid one cycle after the last bit (start + 2*ACC_DATA_WIDTH).
// No backpressure: an early serialStart aborts the partial frame with a frameError pulse and restarts reception.
module deserialization_rx
    import serial_link_pkg::*;
#(
    parameter int ACC_DATA_WIDTH  = ACC_DATA_WIDTH_DEF,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       serialClk,
    input  logic                       reset,
    input  logic                       serialStart,
    input  logic                       serialIn,
    output logic                       dataValid,
    output logic [ACC_DATA_WIDTH-1:0]  dataSA,
    output logic [ACC_DATA_WIDTH-1:0]  dataCML,
    output logic                       frameError,
    output logic [FRAME_CNT_WIDTH-1:0] frameCount,
    output logic                       busy
);

    localparam int FB      = frame_bits(ACC_DATA_WIDTH);
    localparam int SW      = $clog2(FB);
    localparam int IW      = SW + 1;
    localparam int CML_LSB = cml_lsb(ACC_DATA_WIDTH);

    localparam logic [IW-1:0] LAST_IDX = IW'(FB - 1);

    logic [0:0]    state;
    logic [IW-1:0] idx;
    logic [FB-1:0] shift;
    logic [FB-1:0] frame_next;

    // Frame including the bit on the wire this cycle, so the last bit lands directly in the outputs.
    always_comb begin
        frame_next              = shift;
        frame_next[idx[SW-1:0]] = serialIn;
    end

    assign busy = (state == ST_RECV);

    always_ff @(posedge serialClk) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            shift      <= '0;
            dataValid  <= 1'b0;
            frameError <= 1'b0;
            dataSA     <= '0;
            dataCML    <= '0;
            frameCount <= '0;
        end else begin
            dataValid  <= 1'b0;
            frameError <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (serialStart) begin
                        shift <= {{(FB-1){1'b0}}, serialIn};
                        idx   <= IW'(1);
                        state <= ST_RECV;
                    end
                end
                default: begin
                    if (serialStart) begin
                        frameError <= 1'b1;
                        shift      <= {{(FB-1){1'b0}}, serialIn};
                        idx        <= IW'(1);
                    end else if (idx == LAST_IDX) begin
                        dataSA     <= frame_next[SA_LSB +: ACC_DATA_WIDTH];
                        dataCML    <= frame_next[CML_LSB +: ACC_DATA_WIDTH];
                        dataValid  <= 1'b1;
                        frameCount <= frameCount + FRAME_CNT_WIDTH'(1);
                        shift      <= '0;
                        idx        <= '0;
                        state      <= ST_IDLE;
                    end else begin
                        shift <= frame_next;
                        idx   <= idx + IW'(1);
                    end
                end
            endcase
        end
    end

endmodule
